// File: rtl/comb_vector_runner.sv
// comb_vector_runner: replays {stim, expected} vectors into a combinational DUT and tallies mismatches; COMB_VECTOR_RUNNER_STOP_ON_ERR_EN halts on first mismatch
module comb_vector_runner #(
  parameter int IN_W = 4,
  parameter int OUT_W = 1,
  parameter int DEPTH = 16,
  parameter int SETTLE = 1,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_we,
  input  logic [AW-1:0]         ld_addr,
  input  logic [IN_W+OUT_W-1:0] ld_data,
  input  logic [AW:0]           num_vec,
  input  logic                  start,
  output logic [IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]      dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_cnt,
  output logic [AW-1:0]         first_err
);
  localparam int VW = IN_W + OUT_W;
  localparam int SW = SETTLE > 0 ? $clog2(SETTLE + 1) : 1;
  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;
  state_t state, next;
  logic [VW-1:0] mem [DEPTH];
  logic [AW-1:0] idx, last;
  logic [SW-1:0] cnt;
  logic [AW:0] nv;
  logic go, last_v, miss, halt;
  assign go = start && (state == IDLE || state == DONE);
  assign nv = num_vec > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : num_vec;
  assign miss = dut_out != mem[idx][OUT_W-1:0];
  assign last_v = idx == last;
`ifdef COMB_VECTOR_RUNNER_STOP_ON_ERR_EN
  assign halt = miss;
`else
  assign halt = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    unique case (state)
      IDLE, DONE: next = go ? (nv == '0 ? DONE : APPLY) : state;
      APPLY:      next = SETTLE > 0 ? WAIT : CHECK;
      WAIT:       next = cnt == SW'(1) ? CHECK : WAIT;
      CHECK:      next = (last_v || halt) ? DONE : APPLY;
      default:    next = IDLE;
    endcase
  end
  always_comb begin
    busy = state == APPLY || state == WAIT || state == CHECK;
    done = state == DONE;
    pass = done && err_cnt == '0;
  end
  // memory has no reset so loaded vectors survive it
  always_ff @(posedge clk)
    if (ld_we && !busy) mem[ld_addr] <= ld_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      dut_in <= '0;
      err_cnt <= '0;
      first_err <= '0;
      idx <= '0;
      last <= '0;
      cnt <= '0;
    end else if (go) begin
      err_cnt <= '0;
      first_err <= '0;
      idx <= '0;
      last <= AW'(nv - 1'b1);
    end else if (state == APPLY) begin
      dut_in <= mem[idx][VW-1:OUT_W];
      cnt <= SW'(SETTLE);
    end else if (state == WAIT) begin
      cnt <= cnt - 1'b1;
    end else if (state == CHECK) begin
      if (miss && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (miss && err_cnt == '0) first_err <= idx;
      if (!last_v && !halt) idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_comb_vector_runner.sv
// tb_comb_vector_runner: scoreboard bench; runs xor4 vectors through four runner configurations
module tb_comb_vector_runner;
`ifdef COMB_VECTOR_RUNNER_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int passes = 0;
  logic ld_we = 0, start0 = 0, start12 = 0;
  logic [3:0] ld_addr = 0;
  logic [4:0] ld_data = 0, num_vec = 0;
  logic ld_we3 = 0, start3 = 0;
  logic [1:0] ld_addr3 = 0;
  logic [4:0] ld_data3 = 0;
  logic [2:0] num3 = 0;
  logic [3:0] din0, din1, din2, din3;
  logic [0:0] out0, out1, out2, out3;
  logic busy0, busy1, busy2, busy3, done0, done1, done2, done3, pass0, pass1, pass2, pass3;
  logic [15:0] err0, err1, err2, err3;
  logic [3:0] ferr0, ferr1, ferr2;
  logic [1:0] ferr3;
  logic [2:0] p1, p2;
  assign out0 = ^din0;
  assign out3 = ^din3;
  assign out1 = p1[2];
  assign out2 = p2[2];
  // three-register delayed xor4 models a slow DUT path
  always @(posedge clk) begin
    p1 <= reset ? 3'b0 : {p1[1:0], ^din1};
    p2 <= reset ? 3'b0 : {p2[1:0], ^din2};
  end
  comb_vector_runner #(.IN_W(4), .OUT_W(1), .DEPTH(16), .SETTLE(1)) u0 (
    .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .num_vec(num_vec), .start(start0), .dut_in(din0), .dut_out(out0), .busy(busy0),
    .done(done0), .pass(pass0), .err_cnt(err0), .first_err(ferr0));
  comb_vector_runner #(.IN_W(4), .OUT_W(1), .DEPTH(16), .SETTLE(3)) u1 (
    .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .num_vec(num_vec), .start(start12), .dut_in(din1), .dut_out(out1), .busy(busy1),
    .done(done1), .pass(pass1), .err_cnt(err1), .first_err(ferr1));
  comb_vector_runner #(.IN_W(4), .OUT_W(1), .DEPTH(16), .SETTLE(2)) u2 (
    .clk(clk), .reset(reset), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .num_vec(num_vec), .start(start12), .dut_in(din2), .dut_out(out2), .busy(busy2),
    .done(done2), .pass(pass2), .err_cnt(err2), .first_err(ferr2));
  comb_vector_runner #(.IN_W(4), .OUT_W(1), .DEPTH(4), .SETTLE(1)) u3 (
    .clk(clk), .reset(reset), .ld_we(ld_we3), .ld_addr(ld_addr3), .ld_data(ld_data3),
    .num_vec(num3), .start(start3), .dut_in(din3), .dut_out(out3), .busy(busy3),
    .done(done3), .pass(pass3), .err_cnt(err3), .first_err(ferr3));
  typedef struct {
    int id;
    int due;
    logic p;
    logic [15:0] e;
    logic [3:0] f;
    logic [3:0] d;
  } exp_t;
  exp_t sb[$];
  logic [3:0] dns, pss, dprev = 4'b0;
  logic [15:0] errs [4];
  logic [3:0] ferrs [4], dins [4];
  assign dns = {done3, done2, done1, done0};
  assign pss = {pass3, pass2, pass1, pass0};
  assign errs[0] = err0;
  assign errs[1] = err1;
  assign errs[2] = err2;
  assign errs[3] = err3;
  assign ferrs[0] = ferr0;
  assign ferrs[1] = ferr1;
  assign ferrs[2] = ferr2;
  assign ferrs[3] = {2'b0, ferr3};
  assign dins[0] = din0;
  assign dins[1] = din1;
  assign dins[2] = din2;
  assign dins[3] = din3;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, want);
  endtask
  task automatic push(int id, int n, int s, logic p, logic [15:0] e, logic [3:0] f, logic [3:0] d);
    exp_t x;
    x.id = id;
    x.due = cyc + 1 + n * (s + 2);
    x.p = p;
    x.e = e;
    x.f = f;
    x.d = d;
    sb.push_back(x);
  endtask
  function automatic bit has_due(int id);
    foreach (sb[k]) if (sb[k].id == id && sb[k].due == cyc) return 1'b1;
    return 1'b0;
  endfunction
  task automatic pop_check(int id);
    int k = -1;
    exp_t x;
    foreach (sb[j]) if (k < 0 && sb[j].id == id) k = j;
    if (k < 0) begin
      checks++;
      $display("FAIL unexpected_done: runner %0d at cycle %0d", id, cyc);
    end else begin
      x = sb[k];
      sb.delete(k);
      chk($sformatf("r%0d_done_cycle", id), cyc, x.due);
      chk($sformatf("r%0d_pass", id), {31'b0, pss[id]}, {31'b0, x.p});
      chk($sformatf("r%0d_err_cnt", id), {16'b0, errs[id]}, {16'b0, x.e});
      chk($sformatf("r%0d_first_err", id), {28'b0, ferrs[id]}, {28'b0, x.f});
      chk($sformatf("r%0d_dut_in", id), {28'b0, dins[id]}, {28'b0, x.d});
    end
  endtask
  // monitor: a result is presented when done rises or an expected run is due
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++)
      if (dns[i] && (!dprev[i] || has_due(i))) pop_check(i);
    dprev <= dns;
  end
  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL timeout: %0d results never presented", sb.size());
      sb.delete();
    end
  endtask
  task automatic load(int a, logic [4:0] d);
    @(negedge clk);
    ld_we = 1;
    ld_addr = 4'(a);
    ld_data = d;
    @(negedge clk);
    ld_we = 0;
  endtask
  task automatic run0(logic p, logic [15:0] e, logic [3:0] f, logic [3:0] d, int n);
    @(negedge clk);
    num_vec = 5'd16;
    start0 = 1;
    push(0, n, 1, p, e, f, d);
    @(negedge clk);
    start0 = 0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy0}, 0);
    chk("reset_done", {31'b0, done0}, 0);
    chk("reset_pass", {31'b0, pass0}, 0);
    chk("reset_err", {16'b0, err0}, 0);
    chk("reset_first_err", {28'b0, ferr0}, 0);
    chk("reset_dut_in", {28'b0, din0}, 0);
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = i[3:0];
      load(i, {v, ^v});
    end
    run0(1, 0, 0, 4'hF, 16);
    chk("busy_after_start", {31'b0, busy0}, 1);
    wait_idle();
    // slow DUT: settle 3 suffices, settle 2 sees the previous vector's parity
    @(negedge clk);
    num_vec = 5'd16;
    start12 = 1;
    push(1, 16, 3, 1, 0, 0, 4'hF);
    push(2, STOP ? 2 : 16, 2, 0, STOP ? 16'd1 : 16'd10, 4'd1, STOP ? 4'h1 : 4'hF);
    @(negedge clk);
    start12 = 0;
    wait_idle();
    load(5, 5'b0101_1);
    run0(0, 1, 4'd5, STOP ? 4'h5 : 4'hF, STOP ? 6 : 16);
    wait_idle();
    load(5, 5'b0101_0);
    @(negedge clk);
    ld_we = 1;
    ld_addr = 0;
    ld_data = 5'b0000_1;
    num_vec = 5'd16;
    start0 = 1;
    push(0, STOP ? 1 : 16, 1, 0, 1, 0, STOP ? 4'h0 : 4'hF);
    @(negedge clk);
    ld_we = 0;
    start0 = 0;
    wait_idle();
    load(0, 5'b0000_0);
    run0(1, 0, 0, 4'hF, 16);
    repeat (9) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("midrun_reset_busy", {31'b0, busy0}, 0);
    chk("midrun_reset_done", {31'b0, done0}, 0);
    chk("midrun_reset_dut_in", {28'b0, din0}, 0);
    chk("midrun_reset_err", {16'b0, err0}, 0);
    reset = 0;
    void'(sb.pop_back());
    @(negedge clk);
    num_vec = 5'd0;
    start0 = 1;
    push(0, 0, 1, 1, 0, 0, 4'h0);
    @(negedge clk);
    start0 = 0;
    chk("empty_busy", {31'b0, busy0}, 0);
    wait_idle();
    run0(1, 0, 0, 4'hF, 16);
    repeat (5) @(negedge clk);
    start0 = 1;
    num_vec = 5'd2;
    @(negedge clk);
    start0 = 0;
    ld_we = 1;
    ld_addr = 0;
    ld_data = 5'b0000_1;
    @(negedge clk);
    ld_we = 0;
    wait_idle();
    run0(1, 0, 0, 4'hF, 16);
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      logic [3:0] v;
      v = i[3:0];
      @(negedge clk);
      ld_we3 = 1;
      ld_addr3 = v[1:0];
      ld_data3 = {v, ~^v};
    end
    @(negedge clk);
    ld_we3 = 0;
    num3 = 3'd7;
    start3 = 1;
    push(3, STOP ? 1 : 4, 1, 0, STOP ? 16'd1 : 16'd4, 0, STOP ? 4'h0 : 4'h3);
    @(negedge clk);
    start3 = 0;
    wait_idle();
`ifndef COMB_VECTOR_RUNNER_STOP_ON_ERR_EN
    @(negedge clk);
    num3 = 3'd4;
    start3 = 1;
    push(3, 4, 1, 0, 16'hFFFF, 0, 4'h3);
    @(negedge clk);
    start3 = 0;
    repeat (3) @(negedge clk);
    force u3.err_cnt = 16'hFFFE;
    #1 release u3.err_cnt;
    wait_idle();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
